geofence_feeder: RTL and testbench
==================================

Name: geofence_feeder

Overview:
Transmit-side companion to the geofence core. Accepts six receiver records (X, Y, R) from a host over a valid/ready write port and buffers them as one frame. Streams the frame to the core's X/Y/R inputs, one record per cycle for six consecutive cycles. Waits for the core's valid/is_inside pulse and returns the verdict to the host over a valid/ready result port, with a watchdog timeout.

Parameters:
NREC, 6, records per frame (fixed by core; index width 3 bits)
TIMEOUT, 1023, max cycles in WAIT before abort (counter width 10 bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  host record valid
in_ready  output  1  feeder can accept a record
in_x  input  10  record X
in_y  input  10  record Y
in_r  input  11  record R
X  output  10  to core X
Y  output  10  to core Y
R  output  11  to core R
frame_start  output  1  one-cycle pulse aligned with record 0 on X/Y/R
core_valid  input  1  core valid pulse
core_is_inside  input  1  core verdict, sampled when core_valid=1
res_valid  output  1  result available to host
res_ready  input  1  host accepts result
res_inside  output  1  verdict (0 when res_timeout=1)
res_timeout  output  1  frame aborted by watchdog
busy  output  1  state != IDLE

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (reset). All state and outputs are registered.
- Reset values: state=IDLE; wr_cnt=0; send_idx=0; wd_cnt=0. X=0, Y=0, R=0, frame_start=0, res_valid=0, res_inside=0, res_timeout=0, busy=0. in_ready=1 (combinational: state==IDLE && wr_cnt<NREC).
- Buffer: 6 entries of 31 bits {x,y,r}. A write occurs when in_valid&&in_ready; it stores to entry wr_cnt, then wr_cnt++. Writes in any other state are ignored, since in_ready=0.
- FSM states: IDLE, SEND, WAIT, REPORT.
- IDLE: accept writes. The write that makes wr_cnt=6 moves state to SEND on the next edge. There is a 1-cycle gap between the last write and the first record.
- SEND: lasts exactly 6 cycles.
  - In SEND cycle k (k=0..5), X/Y/R = entry k. These are registered outputs, so they are valid for the whole cycle.
  - frame_start=1 only in cycle k=0.
  - After k=5, state goes to WAIT. X/Y/R hold entry 5 through WAIT and REPORT, then return to 0 in IDLE.
- WAIT: wd_cnt increments each cycle from 0.
  - If core_valid=1: capture res_inside=core_is_inside, set res_timeout=0, res_valid=1, go to REPORT.
  - Else if wd_cnt==TIMEOUT-1: set res_timeout=1, res_inside=0, res_valid=1, go to REPORT.
  - If core_valid and the timeout occur in the same cycle, core_valid wins.
- core_valid outside WAIT is ignored: no capture, no state change.
- REPORT: res_valid stays high and res_inside/res_timeout stay stable until res_ready=1.
  - On the handshake cycle: clear res_valid on the next edge, set wr_cnt=0, wd_cnt=0, send_idx=0, state=IDLE.
  - If res_ready is already high on entry to REPORT, res_valid stays high for exactly 1 cycle.
- Latency:
  - Last write to frame_start: 2 edges.
  - core_valid to res_valid: 1 edge.
  - Best case, last write to first write of the next frame: 6 (SEND) + WAIT + 1 (REPORT) + 1 cycles.
- busy=1 in SEND, WAIT and REPORT.
- Reset mid-operation: all state clears immediately (async). The partially buffered frame is discarded and any in-flight result is lost. Buffer contents need no reset; they are not observable until rewritten.
- No arithmetic beyond the counters.
  - wr_cnt and send_idx are 3-bit and never exceed 6 / 5.
  - wd_cnt is 10-bit and saturates; it does not wrap.

Test Plan:
- Basic frame: write (100,100,50),(300,100,60),(400,300,70),(300,500,80),(100,500,90),(20,300,40) back-to-back → in_ready drops after 6th write. Two edges later frame_start=1 with X=100,Y=100,R=50. The next 5 cycles present records 1..5 in order, then state=WAIT.
- Result return: in WAIT, pulse core_valid=1 with core_is_inside=1 → next cycle res_valid=1, res_inside=1, res_timeout=0. Hold res_ready=0 for 5 cycles → outputs stable. res_ready=1 → res_valid=0 and in_ready=1 next cycle.
- Host throttling: in_valid toggles 1,0,1,0 across 12 cycles → exactly 6 records captured in order. No SEND before the 6th accepted write.
- Timeout: no core_valid for TIMEOUT cycles → res_valid=1, res_timeout=1, res_inside=0. Then core_valid pulse in REPORT → ignored, result unchanged.
- Simultaneous: core_valid=1 on the exact timeout cycle → res_timeout=0, res_inside=core_is_inside. Stray core_valid during IDLE or SEND → no effect.
- Reset mid-SEND: assert reset at SEND cycle 3 → same-cycle X/Y/R=0, busy=0, in_ready=1. A fresh 6-record frame then streams correctly.

Source files
------------

// File: rtl/geofence_feeder.sv
// Host-side feeder for the geofence core: buffers six (X,Y,R) records,
// streams them to the core, and returns the verdict with a watchdog.
module geofence_feeder #(
  parameter int NREC    = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic [10:0] in_r,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic [10:0] R,
  output logic        frame_start,
  input  logic        core_valid,
  input  logic        core_is_inside,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_inside,
  output logic        res_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam logic [2:0] FULL   = 3'(NREC);
  localparam logic [2:0] LAST   = 3'(NREC - 1);
  localparam logic [9:0] WD_LIM = 10'(TIMEOUT - 1);

  state_t      r_state;
  logic [2:0]  r_wr_cnt;
  logic [2:0]  r_send_idx;
  logic [9:0]  r_wd_cnt;
  logic [30:0] r_buf [NREC];

  logic        w_wr;
  logic [2:0]  w_next_idx;

  assign in_ready   = (r_state == S_IDLE) && (r_wr_cnt < FULL);
  assign w_wr       = in_valid && in_ready;
  assign w_next_idx = r_send_idx + 3'd1;

  // Frame storage needs no reset: entries are rewritten before use.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_buf[r_wr_cnt] <= {in_x, in_y, in_r};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_cnt    <= '0;
      r_send_idx  <= '0;
      r_wd_cnt    <= '0;
      X           <= '0;
      Y           <= '0;
      R           <= '0;
      frame_start <= 1'b0;
      res_valid   <= 1'b0;
      res_inside  <= 1'b0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            r_wr_cnt <= r_wr_cnt + 3'd1;
          end else if (r_wr_cnt == FULL) begin
            r_state     <= S_SEND;
            r_send_idx  <= '0;
            {X, Y, R}   <= r_buf[0];
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_SEND: begin
          frame_start <= 1'b0;
          if (r_send_idx == LAST) begin
            r_state  <= S_WAIT;
            r_wd_cnt <= '0;
          end else begin
            r_send_idx <= w_next_idx;
            {X, Y, R}  <= r_buf[w_next_idx];
          end
        end
        S_WAIT: begin
          // A core verdict takes priority over a coincident timeout.
          if (core_valid) begin
            res_inside  <= core_is_inside;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            r_state     <= S_REPORT;
          end else if (r_wd_cnt == WD_LIM) begin
            res_inside  <= 1'b0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            r_state     <= S_REPORT;
          end else if (r_wd_cnt != '1) begin
            r_wd_cnt <= r_wd_cnt + 10'd1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            res_inside  <= 1'b0;
            res_timeout <= 1'b0;
            r_wr_cnt    <= '0;
            r_wd_cnt    <= '0;
            r_send_idx  <= '0;
            X           <= '0;
            Y           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed-plus-random bench for geofence_feeder against a frame-level
// model of the record stream, result return and watchdog.
module tb_geofence_feeder;

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic [10:0] in_r;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic [10:0] R;
  logic        frame_start;
  logic        core_valid;
  logic        core_is_inside;
  logic        res_valid;
  logic        res_ready;
  logic        res_inside;
  logic        res_timeout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]  ex [6];
  logic [9:0]  ey [6];
  logic [10:0] er [6];

  int bx [6] = '{100, 300, 400, 300, 100, 20};
  int by [6] = '{100, 100, 300, 500, 500, 300};
  int br [6] = '{50, 60, 70, 80, 90, 40};

  geofence_feeder #(.NREC(6), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .in_r(in_r),
    .X(X),
    .Y(Y),
    .R(R),
    .frame_start(frame_start),
    .core_valid(core_valid),
    .core_is_inside(core_is_inside),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_inside(res_inside),
    .res_timeout(res_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic junk;
    in_x = 10'($urandom);
    in_y = 10'($urandom);
    in_r = 11'($urandom);
  endtask

  // Writes one frame, then follows the stream into WAIT (or aborts in SEND).
  task automatic run_frame(input bit basic, input bit throttle,
                           input bit stray, input int abort_at);
    int acc = 0;
    int cyc = 0;
    while (acc < 6) begin
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("fs_idle", 32'(frame_start), 32'd0);
      in_valid = throttle ? ~cyc[0] : 1'b1;
      if (in_valid && basic) begin
        in_x = 10'(bx[acc]);
        in_y = 10'(by[acc]);
        in_r = 11'(br[acc]);
      end else begin
        junk();
      end
      if (in_valid) begin
        ex[acc] = in_x;
        ey[acc] = in_y;
        er[acc] = in_r;
      end
      core_valid = stray ? 1'($urandom) : 1'b0;
      core_is_inside = 1'($urandom);
      tick();
      if (in_valid) acc++;
      cyc++;
    end
    in_valid = 1'b1;
    junk();
    chk("in_ready_full", 32'(in_ready), 32'd0);
    chk("busy_gap", 32'(busy), 32'd0);
    chk("fs_gap", 32'(frame_start), 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("fs_send", 32'(frame_start), 32'(k == 0));
      chk("x_send", 32'(X), 32'(ex[k]));
      chk("y_send", 32'(Y), 32'(ey[k]));
      chk("r_send", 32'(R), 32'(er[k]));
      chk("busy_send", 32'(busy), 32'd1);
      chk("rv_send", 32'(res_valid), 32'd0);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_x", 32'(X), 32'd0);
        chk("rst_y", 32'(Y), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        in_valid = 1'b0;
        core_valid = 1'b0;
        tick();
        reset = 1'b0;
        return;
      end
      junk();
      core_valid = stray ? 1'($urandom) : 1'b0;
      tick();
    end
    in_valid = 1'b0;
    core_valid = 1'b0;
    chk("x_hold", 32'(X), 32'(ex[5]));
    chk("r_hold", 32'(R), 32'(er[5]));
    chk("busy_wait", 32'(busy), 32'd1);
    chk("rv_wait", 32'(res_valid), 32'd0);
  endtask

  // Waits a few cycles in WAIT, then the core reports verdict v.
  task automatic core_reply(input int wcyc, input bit v);
    for (int i = 0; i < wcyc; i++) begin
      tick();
      chk("rv_waiting", 32'(res_valid), 32'd0);
    end
    core_valid = 1'b1;
    core_is_inside = v;
    tick();
    core_valid = 1'b0;
    chk("rv_reply", 32'(res_valid), 32'd1);
    chk("inside_reply", 32'(res_inside), 32'(v));
    chk("tmo_reply", 32'(res_timeout), 32'd0);
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("rv_done", 32'(res_valid), 32'd0);
    chk("in_ready_done", 32'(in_ready), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("x_done", 32'(X), 32'd0);
  endtask

  initial begin
    bit v;
    reset = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_r = '0;
    core_valid = 1'b0;
    core_is_inside = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_xyr", 32'({X, Y, R}), 32'd0);
    chk("reset_fs", 32'(frame_start), 32'd0);
    chk("reset_rv", 32'({res_valid, res_inside, res_timeout}), 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame, verdict held against a stalled host.
    run_frame(1'b1, 1'b0, 1'b0, -1);
    core_reply(3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rv_stall", 32'(res_valid), 32'd1);
      chk("inside_stall", 32'(res_inside), 32'd1);
      chk("tmo_stall", 32'(res_timeout), 32'd0);
    end
    handshake();

    // Throttled host, stray core pulses, host ready on entry.
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 1'b1, 1'b1, -1);
      v = 1'($urandom);
      res_ready = 1'b1;
      core_reply(int'($urandom_range(0, 20)), v);
      tick();
      res_ready = 1'b0;
      chk("rv_one_cycle", 32'(res_valid), 32'd0);
      chk("in_ready_next", 32'(in_ready), 32'd1);
    end

    // Watchdog expiry, then a late core pulse must be ignored.
    run_frame(1'b0, 1'b0, 1'b0, -1);
    for (int n = 1; n <= TMO; n++) begin
      tick();
      if (n >= TMO - 2)
        chk("rv_watchdog", 32'(res_valid), 32'(n == TMO));
    end
    chk("tmo_flag", 32'(res_timeout), 32'd1);
    chk("tmo_inside", 32'(res_inside), 32'd0);
    core_valid = 1'b1;
    core_is_inside = 1'b1;
    tick();
    core_valid = 1'b0;
    chk("late_rv", 32'(res_valid), 32'd1);
    chk("late_tmo", 32'(res_timeout), 32'd1);
    chk("late_inside", 32'(res_inside), 32'd0);
    handshake();

    // Core reply on the final watchdog cycle wins.
    run_frame(1'b0, 1'b1, 1'b0, -1);
    for (int n = 1; n < TMO; n++) tick();
    chk("rv_pre_tmo", 32'(res_valid), 32'd0);
    core_valid = 1'b1;
    core_is_inside = 1'b1;
    tick();
    core_valid = 1'b0;
    chk("sim_rv", 32'(res_valid), 32'd1);
    chk("sim_tmo", 32'(res_timeout), 32'd0);
    chk("sim_inside", 32'(res_inside), 32'd1);
    handshake();

    // Reset in SEND cycle 3, then a fresh frame.
    run_frame(1'b0, 1'b0, 1'b1, 3);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    run_frame(1'b0, 1'b0, 1'b0, -1);
    core_reply(5, 1'b0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
